// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_ctrl
//  Brief    : Two-state issue sequencer that drives a combinational ALU from
//             a 4-entry register file and writes the result back.
//  Revision : 1.0  initial release
// ============================================================================

module alu_seq_ctrl #(
    parameter int DATA_W       = 4,
    parameter bit R0_HARDWIRED = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [7:0]        instr_in,
    output logic              instr_ready,
    input  logic              ld_en,
    input  logic [1:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              done_valid,
    output logic [DATA_W-1:0] done_data,
    output logic              done_zero,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_regs [4];
    logic [1:0]        r_rd;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [1:0]        r_alu_op;
    logic              r_done_valid;
    logic [DATA_W-1:0] r_done_data;
    logic              r_done_zero;

    logic [1:0]        w_op;
    logic [1:0]        w_rd;
    logic [1:0]        w_rs1;
    logic [1:0]        w_rs2;
    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;

    logic              w_accept;
    logic              w_retire;
    logic              w_load;
    logic              w_wr_en;
    logic [1:0]        w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;

    assign w_op  = instr_in[7:6];
    assign w_rd  = instr_in[5:4];
    assign w_rs1 = instr_in[3:2];
    assign w_rs2 = instr_in[1:0];

    // With a hardwired R0 the storage is never written, but the read mask
    // keeps the zero guarantee independent of the write path.
    assign w_rs1_val = (R0_HARDWIRED && (w_rs1 == 2'd0)) ? '0 : r_regs[w_rs1];
    assign w_rs2_val = (R0_HARDWIRED && (w_rs2 == 2'd0)) ? '0 : r_regs[w_rs2];
    assign dbg_data  = (R0_HARDWIRED && (dbg_addr == 2'd0)) ? '0 : r_regs[dbg_addr];

    // Next-state and per-cycle control decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_retire    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (instr_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXEC;
                end else if (ld_en) begin
                    w_load = 1'b1;
                end
            end
            S_EXEC: begin
                w_retire    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Single write port shared by retire and load; they are mutually exclusive by state.
    always_comb begin
        w_wr_addr = w_retire ? r_rd       : ld_addr;
        w_wr_data = w_retire ? alu_result : ld_data;
        w_wr_en   = (w_retire || w_load) && !(R0_HARDWIRED && (w_wr_addr == 2'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd     <= 2'd0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= 2'd0;
        end else if (w_accept) begin
            r_rd     <= w_rd;
            r_alu_a  <= w_rs1_val;
            r_alu_b  <= w_rs2_val;
            r_alu_op <= w_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_valid <= 1'b0;
            r_done_data  <= '0;
            r_done_zero  <= 1'b0;
        end else begin
            r_done_valid <= w_retire;
            if (w_retire) begin
                r_done_data <= alu_result;
                r_done_zero <= alu_zero;
            end
        end
    end

    assign instr_ready = (r_state == S_IDLE);
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign done_valid  = r_done_valid;
    assign done_data   = r_done_data;
    assign done_zero   = r_done_zero;

endmodule

`default_nettype wire
